// File: rtl/if1_fetch_if.sv
// Fetch-stage bus bundle: stall/redirect inputs from the pipeline, instruction-SRAM request
// and IF1->IF2 payload outputs. The master modport is the fetch unit.
interface if1_fetch_if #(parameter int STALL_W = 6);
  logic [STALL_W-1:0] stall;
  logic               br_e;
  logic [31:0]        br_addr;
  logic [33:0]        if12if2_bus;
  logic               inst_sram_en;
  logic [3:0]         inst_sram_we;
  logic [31:0]        inst_sram_addr;
  logic [31:0]        inst_sram_wdata;
  logic [31:0]        fetch_cnt;

  modport master (
    input  stall, br_e, br_addr,
    output if12if2_bus, inst_sram_en, inst_sram_we, inst_sram_addr, inst_sram_wdata, fetch_cnt
  );

  modport slave (
    output stall, br_e, br_addr,
    input  if12if2_bus, inst_sram_en, inst_sram_we, inst_sram_addr, inst_sram_wdata, fetch_cnt
  );
endinterface

// File: rtl/if1_fetch.sv
// IF1 fetch stage: PC register with redirect, stall-deferred redirect and misaligned-PC marking.
// Optional fetch counter enabled by defining IF1_FETCH_CNT_EN.
module if1_fetch #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
  input logic          clk,
  input logic          rst_n,
  if1_fetch_if.master  bus
);
  logic [31:0] pc_r;
  logic        valid_r;
  logic        pend_v;
  logic [31:0] pend_addr;
  logic        stall0;
  logic        adel;
  logic        fetch;
  logic        unused_stall;

  assign stall0       = bus.stall[0];
  assign unused_stall = ^bus.stall;

  assign adel  = (pc_r[1:0] != 2'b00) & valid_r;
  assign fetch = valid_r & ~pend_v & ~adel;

  assign bus.inst_sram_en    = fetch;
  assign bus.inst_sram_addr  = pc_r;
  assign bus.inst_sram_we    = 4'b0000;
  assign bus.inst_sram_wdata = 32'h0;
  assign bus.if12if2_bus     = {adel, fetch, pc_r};

  // A redirect that lands during a stall is parked; the newest target overwrites the parked one.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_r      <= RESET_PC;
      valid_r   <= 1'b0;
      pend_v    <= 1'b0;
      pend_addr <= 32'h0;
    end else if (bus.br_e) begin
      if (!stall0) begin
        pc_r    <= bus.br_addr;
        valid_r <= 1'b1;
        pend_v  <= 1'b0;
      end else begin
        pend_addr <= bus.br_addr;
        pend_v    <= 1'b1;
      end
    end else if (!stall0) begin
      if (pend_v) begin
        pc_r    <= pend_addr;
        pend_v  <= 1'b0;
        valid_r <= 1'b1;
      end else if (!valid_r) begin
        valid_r <= 1'b1;
      end else begin
        pc_r <= pc_r + 32'd4;
      end
    end
  end

`ifdef IF1_FETCH_CNT_EN
  logic [31:0] cnt_r;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_r <= 32'h0;
    end else if (fetch && !stall0) begin
      cnt_r <= cnt_r + 32'd1;
    end
  end

  assign bus.fetch_cnt = cnt_r;
`else
  assign bus.fetch_cnt = 32'h0;
`endif
endmodule

// File: tb/tb_if1_fetch.sv
// Self-checking bench for if1_fetch: directed vector table, counter sequence, and random
// stimulus against a queue-based reference model of the fetch address stream.
module tb_if1_fetch;
  localparam logic [31:0] RESET_PC = 32'h8000_0000;
`ifdef IF1_FETCH_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic clk;
  logic rst_n;
  int   n_chk;
  int   n_fail;

  if1_fetch_if #(.STALL_W(6)) bus ();

  if1_fetch #(.RESET_PC(RESET_PC)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: current address, whether fetching has begun, and at most one parked target.
  logic [31:0] m_pc;
  bit          m_started;
  logic [31:0] m_redirect[$];
  logic [31:0] m_cnt;

  function automatic bit m_adel();
    return m_started && (m_pc[1:0] != 2'b00);
  endfunction

  function automatic bit m_fetching();
    return m_started && (m_redirect.size() == 0) && !m_adel();
  endfunction

  task automatic model_update(input logic r, input logic [5:0] s, input logic b, input logic [31:0] a);
    if (!r) begin
      m_pc      = RESET_PC;
      m_started = 0;
      m_redirect.delete();
      m_cnt     = 32'h0;
    end else begin
      if (CNT_EN && m_fetching() && !s[0]) m_cnt = m_cnt + 1;
      if (b) begin
        if (s[0]) begin
          m_redirect.delete();
          m_redirect.push_back(a);
        end else begin
          m_pc = a;
          m_started = 1;
          m_redirect.delete();
        end
      end else if (!s[0]) begin
        if (m_redirect.size() != 0) begin
          m_pc = m_redirect.pop_front();
          m_started = 1;
        end else if (!m_started) begin
          m_started = 1;
        end else begin
          m_pc = m_pc + 32'd4;
        end
      end
    end
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_model();
    chk("model_bus", {30'h0, bus.if12if2_bus}, {30'h0, m_adel(), m_fetching(), m_pc});
    chk("model_en", {63'h0, bus.inst_sram_en}, {63'h0, m_fetching()});
    chk("model_addr", {32'h0, bus.inst_sram_addr}, {32'h0, m_pc});
    chk("model_cnt", {32'h0, bus.fetch_cnt}, {32'h0, m_cnt});
    chk("model_we_wdata", {28'h0, bus.inst_sram_we, bus.inst_sram_wdata}, 64'h0);
  endtask

  task automatic step(input logic r, input logic [5:0] s, input logic b, input logic [31:0] a);
    rst_n = r;
    bus.stall = s;
    bus.br_e = b;
    bus.br_addr = a;
    model_update(r, s, b, a);
    @(posedge clk);
    #1;
    check_model();
  endtask

  typedef struct {
    logic        r;
    logic [5:0]  s;
    logic        b;
    logic [31:0] a;
    logic        en;
    logic        vld;
    logic        adel;
    logic [31:0] pc;
  } vec_t;

  function automatic vec_t v(input logic r, input logic [5:0] s, input logic b, input logic [31:0] a,
                             input logic en, input logic vld, input logic adel, input logic [31:0] pc);
    vec_t t;
    t.r = r; t.s = s; t.b = b; t.a = a;
    t.en = en; t.vld = vld; t.adel = adel; t.pc = pc;
    return t;
  endfunction

  vec_t tbl[21];

  initial begin
    logic        r;
    logic [5:0]  s;
    logic        b;
    logic [31:0] a;

    n_chk = 0;
    n_fail = 0;
    m_pc = RESET_PC;
    m_started = 0;
    m_cnt = 32'h0;
    rst_n = 1'b0;
    bus.stall = '0;
    bus.br_e = 1'b0;
    bus.br_addr = 32'h0;

    //            rst  stall     br  br_addr        en vld adel pc
    tbl[0]  = v(1'b0, 6'h00, 1'b0, 32'h0,          0, 0, 0, 32'h8000_0000);
    tbl[1]  = v(1'b0, 6'h01, 1'b1, 32'h1234_5678,  0, 0, 0, 32'h8000_0000);
    tbl[2]  = v(1'b1, 6'h00, 1'b0, 32'h0,          1, 1, 0, 32'h8000_0000);
    tbl[3]  = v(1'b1, 6'h00, 1'b0, 32'h0,          1, 1, 0, 32'h8000_0004);
    tbl[4]  = v(1'b1, 6'h00, 1'b1, 32'h8000_0100,  1, 1, 0, 32'h8000_0100);
    tbl[5]  = v(1'b1, 6'h00, 1'b0, 32'h0,          1, 1, 0, 32'h8000_0104);
    tbl[6]  = v(1'b1, 6'h01, 1'b1, 32'h8000_0200,  0, 0, 0, 32'h8000_0104);
    tbl[7]  = v(1'b1, 6'h01, 1'b0, 32'h0,          0, 0, 0, 32'h8000_0104);
    tbl[8]  = v(1'b1, 6'h01, 1'b1, 32'h8000_0300,  0, 0, 0, 32'h8000_0104);
    tbl[9]  = v(1'b1, 6'h00, 1'b0, 32'h0,          1, 1, 0, 32'h8000_0300);
    tbl[10] = v(1'b1, 6'h00, 1'b0, 32'h0,          1, 1, 0, 32'h8000_0304);
    tbl[11] = v(1'b1, 6'h00, 1'b1, 32'h8000_0102,  0, 0, 1, 32'h8000_0102);
    tbl[12] = v(1'b1, 6'h00, 1'b0, 32'h0,          0, 0, 1, 32'h8000_0106);
    tbl[13] = v(1'b1, 6'h00, 1'b1, 32'hFFFF_FFFC,  1, 1, 0, 32'hFFFF_FFFC);
    tbl[14] = v(1'b1, 6'h00, 1'b0, 32'h0,          1, 1, 0, 32'h0000_0000);
    tbl[15] = v(1'b1, 6'h01, 1'b0, 32'h0,          1, 1, 0, 32'h0000_0000);
    tbl[16] = v(1'b1, 6'h3E, 1'b0, 32'h0,          1, 1, 0, 32'h0000_0004);
    tbl[17] = v(1'b1, 6'h01, 1'b1, 32'h0000_0500,  0, 0, 0, 32'h0000_0004);
    tbl[18] = v(1'b0, 6'h00, 1'b0, 32'h0,          0, 0, 0, 32'h8000_0000);
    tbl[19] = v(1'b1, 6'h00, 1'b0, 32'h0,          1, 1, 0, 32'h8000_0000);
    tbl[20] = v(1'b1, 6'h00, 1'b0, 32'h0,          1, 1, 0, 32'h8000_0004);

    for (int i = 0; i < 21; i++) begin
      step(tbl[i].r, tbl[i].s, tbl[i].b, tbl[i].a);
      chk($sformatf("vec%0d_en", i), {63'h0, bus.inst_sram_en}, {63'h0, tbl[i].en});
      chk($sformatf("vec%0d_bus", i), {30'h0, bus.if12if2_bus},
          {30'h0, tbl[i].adel, tbl[i].vld, tbl[i].pc});
      chk($sformatf("vec%0d_addr", i), {32'h0, bus.inst_sram_addr}, {32'h0, tbl[i].pc});
    end

    // Counter: one start-up cycle, ten fetching cycles, then two stalled cycles.
    step(1'b0, 6'h00, 1'b0, 32'h0);
    chk("cnt_reset", {32'h0, bus.fetch_cnt}, 64'h0);
    for (int i = 0; i < 11; i++) step(1'b1, 6'h00, 1'b0, 32'h0);
    step(1'b1, 6'h01, 1'b0, 32'h0);
    step(1'b1, 6'h01, 1'b0, 32'h0);
    chk("cnt_after_10", {32'h0, bus.fetch_cnt}, CNT_EN ? 64'd10 : 64'd0);

    // Stall released during start-up must not skip RESET_PC.
    step(1'b0, 6'h00, 1'b0, 32'h0);
    step(1'b1, 6'h01, 1'b0, 32'h0);
    chk("startup_stall_en", {63'h0, bus.inst_sram_en}, 64'h0);
    step(1'b1, 6'h00, 1'b0, 32'h0);
    chk("startup_first_pc", {32'h0, bus.inst_sram_addr}, {32'h0, RESET_PC});

    for (int i = 0; i < 500; i++) begin
      r = ($urandom_range(99) != 0);
      s = 6'($urandom);
      s[0] = ($urandom_range(9) < 3);
      b = ($urandom_range(4) == 0);
      a = $urandom;
      if ($urandom_range(7) != 0) a[1:0] = 2'b00;
      step(r, s, b, a);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/if1_fetch.md
IF1_FETCH -- requirements
Module: if1_fetch

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h8000_0000, the first fetch address after reset.
REQ-002 SHALL have port clk  input  1  rising-edge clock.
REQ-003 SHALL have port rst_n  input  1  reset; synchronous, active-low; clock clk.
REQ-004 SHALL have port stall  input  `StallBus  pipeline stall vector; bit 0 freezes the PC, other bits are ignored.
REQ-005 SHALL have port br_e  input  1  branch/redirect request from execute.
REQ-006 SHALL have port br_addr  input  32  redirect target.
REQ-007 SHALL have port if12if2_bus  output  `IF12IF2_WD (34)  packed as {adel, valid, pc[31:0]}.
REQ-008 SHALL have port inst_sram_en  output  1  fetch request.
REQ-009 SHALL have port inst_sram_we  output  4  byte write enables.
REQ-010 SHALL have port inst_sram_addr  output  32  fetch address.
REQ-011 SHALL have port inst_sram_wdata  output  32  write data.
REQ-012 SHALL have port fetch_cnt  output  32  count of issued fetches (see Configuration).

Function
REQ-013 SHALL hold the state pc_r (32 bits), valid_r, pend_v and pend_addr (32 bits).
REQ-014 SHALL drive inst_sram_addr = pc_r and if12if2_bus.pc = pc_r combinationally.
REQ-015 SHALL drive if12if2_bus.valid = valid_r & ~pend_v & ~adel.
REQ-016 SHALL drive adel = (pc_r[1:0] != 0) & valid_r.
REQ-017 SHALL drive inst_sram_en = valid_r & ~pend_v & ~adel.
REQ-018 SHALL tie inst_sram_we = 4'b0 and inst_sram_wdata = 0.
REQ-019 SHALL apply next-state priority per clock as follows: redirect, then pending redirect, then start-up, then sequential, then hold.
REQ-020 SHALL, when br_e=1 and stall[0]=0: set pc_r <= br_addr, set valid_r <= 1, and clear pend_v.
REQ-021 SHALL, when br_e=1 and stall[0]=1: set pend_addr <= br_addr and pend_v <= 1, and leave pc_r unchanged.
REQ-022 SHALL, on a later br_e while pend_v=1, overwrite pend_addr; the newest target wins.
REQ-023 SHALL, when br_e=0, pend_v=1 and stall[0]=0: set pc_r <= pend_addr, pend_v <= 0 and valid_r <= 1.
REQ-024 SHALL, when valid_r=0 and stall[0]=0: set valid_r <= 1 and keep pc_r, so RESET_PC is the first address fetched.
REQ-025 SHALL, when valid_r=1, pend_v=0, br_e=0 and stall[0]=0: set pc_r <= pc_r + 4, wrapping modulo 2^32 (32'hFFFF_FFFC wraps to 0).
REQ-026 SHALL, when stall[0]=1 and br_e=0, hold all state and keep outputs stable so the fetch re-issues the same address.
REQ-027 SHALL, on a misaligned PC (adel=1), still advance per REQ-025 and present the bus with adel=1 and valid=0, giving one exception marker per address.
REQ-028 SHALL produce each bus value in the same cycle as its inst_sram request; the SRAM read data arrives the following cycle.

Reset
REQ-029 SHALL, on rst_n=0 at a clock edge, set pc_r=RESET_PC, valid_r=0, pend_v=0, pend_addr=0 and fetch_cnt=0.
REQ-030 SHALL, during reset, present inst_sram_en=0 and if12if2_bus = {1'b0, 1'b0, RESET_PC}.
REQ-031 SHALL give reset priority over br_e and stall, discarding a pending redirect when reset is asserted mid-operation.

Configuration
REQ-032 SHALL, with macro IF1_FETCH_CNT_EN defined, increment fetch_cnt by 1 at each edge where inst_sram_en=1 and stall[0]=0, wrapping from 32'hFFFF_FFFF to 0.
REQ-033 SHALL, without IF1_FETCH_CNT_EN, tie fetch_cnt to 0 and synthesize no counter register.

Verification
REQ-034 SHALL cover reset release with stall=0: cycle 1 gives en=0, cycle 2 gives addr=8000_0000 with valid=1, cycle 3 gives addr=8000_0004.
REQ-035 SHALL cover br_e=1 with br_addr=8000_0100 and no stall: the next cycle gives addr=8000_0100, then 8000_0104.
REQ-036 SHALL cover stall[0]=1 for 3 cycles with br_e pulsed to 8000_0200 and then to 8000_0300: bus valid=0 while stalled; after stall release the next cycle gives addr=8000_0300.
REQ-037 SHALL cover br_addr=8000_0102: the following cycle gives adel=1, valid=0, en=0, and the cycle after gives pc=8000_0106.
REQ-038 SHALL cover pc_r preloaded to FFFF_FFFC by a redirect: the next cycle gives addr=0000_0000.
REQ-039 SHALL cover, with IF1_FETCH_CNT_EN defined, 10 unstalled fetches followed by 2 stalled cycles: fetch_cnt=10; with the macro undefined, fetch_cnt stays 0.
